// File: rtl/fetch_pkg.sv
// Shared types for the fetch -> decode path: machine-word typedefs and the
// packet that travels through the fetch queue.
package fetch_pkg;

  typedef logic [31:0] w32;
  typedef logic [15:0] w16;

  // One fetched packet as it is held in the queue.
  typedef struct packed {
    w32   instr;
    w16   pc;
    logic approx;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = 49;

  // Bundle loose port fields into a queue entry.
  function automatic fetch_entry_t make_entry(input w32 instr, input w16 pc, input logic approx);
    fetch_entry_t e;
    e.instr  = instr;
    e.pc     = pc;
    e.approx = approx;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port so the head entry is visible in the same cycle.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the incoming packet into its slot.
  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so clearing the array would only cost flops.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode. Fetch offers packets
// with in_en and is held off by in_reject; decode takes the head with out_en
// and holds it with out_reject. A mispredict flush empties the queue.
// Optional feature macro FETCH_QUEUE_BYPASS_EN: when the queue is empty the
// incoming packet is passed straight to decode in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_en,
  input  w32               in_instr,
  input  w16               in_pc,
  input  logic             in_approx,
  output logic             in_reject,
  output logic             out_en,
  output w32               out_instr,
  output w16               out_pc,
  output logic             out_approx,
  input  logic             out_reject,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             ram_valid;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             bypass_taken;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head_entry;
  fetch_entry_t     out_entry;

  // Assert internal reset immediately, release it two clocks after reset rises.
  // NOTE: assertion is asynchronous but release goes through two flops so the
  // pointer flops never see a reset edge close to the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_reject = full;
  assign ram_valid = ~empty & ~flush;
  assign wr_entry  = make_entry(in_instr, in_pc, in_approx);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass       = empty & in_en & ~flush;
  assign bypass_taken = bypass & ~out_reject;
  assign out_en       = ram_valid | bypass;
  assign out_entry    = bypass ? wr_entry : head_entry;
`else
  assign bypass       = 1'b0;
  assign bypass_taken = bypass;
  assign out_en       = ram_valid;
  assign out_entry    = head_entry;
`endif

  // A bypassed packet that decode accepts is never written into storage.
  assign push = in_en & ~in_reject & ~flush & ~bypass_taken;
  assign pop  = ram_valid & ~out_reject;

  assign out_instr  = out_entry.instr;
  assign out_pc     = out_entry.pc;
  assign out_approx = out_entry.approx;
  assign occupancy  = count;

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  // Advance pointers and count; flush discards everything at the next edge.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Count must stay within 0..DEPTH.
  assert property (@(posedge clock) disable iff (!rst_int_n) count <= FULL_CNT);
  assert property (@(posedge clock) disable iff (!rst_int_n) !(pop && empty));
  assert property (@(posedge clock) disable iff (!rst_int_n) !(push && full));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, streaming with wrap, flush
// (including while full), mid-stream reset and, when FETCH_QUEUE_BYPASS_EN is
// defined, zero-latency pass-through.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           flush = 1'b0;
  logic           in_en = 1'b0;
  w32             in_instr = '0;
  w16             in_pc = '0;
  logic           in_approx = 1'b0;
  logic           in_reject;
  logic           out_en;
  w32             out_instr;
  w16             out_pc;
  logic           out_approx;
  logic           out_reject = 1'b1;
  logic [PTR_W:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_en      (in_en),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_approx  (in_approx),
    .in_reject  (in_reject),
    .out_en     (out_en),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_approx (out_approx),
    .out_reject (out_reject),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Present a packet whose instr and approx are derived from its pc.
  task automatic drive(input logic en, input w16 pc);
    in_en     = en;
    in_pc     = pc;
    in_instr  = {16'hC0DE, pc};
    in_approx = pc[0];
  endtask

  initial begin
    // Reset held for three cycles
    drive(1'b0, 16'h0);
    repeat (3) next_cycle();
    #1;
    check("rst_out_en", 32'(out_en), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_reject", 32'(in_reject), 32'd0);
    reset = 1'b1;
    repeat (3) next_cycle();

    // Fill to DEPTH with decode stalled; fifth packet is refused
    out_reject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i));
      #1;
      check("fill_in_reject", 32'(in_reject), 32'd0);
      next_cycle();
    end
    drive(1'b1, 16'h0004);
    #1;
    check("full_occupancy", 32'(occupancy), 32'd4);
    check("full_in_reject", 32'(in_reject), 32'd1);
    check("full_out_en", 32'(out_en), 32'd1);
    check("full_head_pc", 32'(out_pc), 32'h0000);
    next_cycle();

    // Drain in order; in_reject drops after the first pop
    drive(1'b0, 16'h0);
    out_reject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_out_en", 32'(out_en), 32'd1);
      check("drain_out_pc", 32'(out_pc), 32'(i));
      check("drain_out_instr", out_instr, {16'hC0DE, 16'(i)});
      check("drain_out_approx", 32'(out_approx), 32'(i % 2));
      check("drain_occupancy", 32'(occupancy), 32'(4 - i));
      check("drain_in_reject", 32'(in_reject), (i == 0) ? 32'd1 : 32'd0);
      next_cycle();
    end
    #1;
    check("drained_occupancy", 32'(occupancy), 32'd0);
    check("drained_out_en", 32'(out_en), 32'd0);

    // Streaming: 10 packets back-to-back, pointers wrap
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, 16'(16'h0010 + i));
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (i < 10) begin
        check("stream_out_en", 32'(out_en), 32'd1);
        check("stream_out_pc", 32'(out_pc), 32'(16'h0010 + i));
      end
      check("stream_occupancy", 32'(occupancy), 32'd0);
`else
      if (i > 0) begin
        check("stream_out_en", 32'(out_en), 32'd1);
        check("stream_out_pc", 32'(out_pc), 32'(16'h0010 + i - 1));
        check("stream_occupancy", 32'(occupancy), 32'd1);
      end else begin
        check("stream_first_out_en", 32'(out_en), 32'd0);
      end
`endif
      next_cycle();
    end
    drive(1'b0, 16'h0);
    #1;
    check("stream_end_occupancy", 32'(occupancy), 32'd0);

    // Flush with three entries queued and a packet offered in the flush cycle
    out_reject = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b1, 16'(16'h0020 + i));
    end
    next_cycle();
    flush = 1'b1;
    drive(1'b1, 16'h0100);
    #1;
    check("flush_out_en", 32'(out_en), 32'd0);
    check("flush_occupancy_pre", 32'(occupancy), 32'd3);
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 16'h0);
    #1;
    check("flush_occupancy_post", 32'(occupancy), 32'd0);
    check("flush_out_en_post", 32'(out_en), 32'd0);
    next_cycle();
    drive(1'b1, 16'h0200);
    next_cycle();
    drive(1'b0, 16'h0);
    #1;
    check("post_flush_out_pc", 32'(out_pc), 32'h0200);
    check("post_flush_occupancy", 32'(occupancy), 32'd1);
    out_reject = 1'b0;
    next_cycle();
    #1;
    check("post_flush_drained", 32'(occupancy), 32'd0);

    // Flush while full: in_reject holds for the flush cycle only
    out_reject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0050 + i));
      next_cycle();
    end
    drive(1'b0, 16'h0);
    flush = 1'b1;
    #1;
    check("flush_full_in_reject", 32'(in_reject), 32'd1);
    check("flush_full_out_en", 32'(out_en), 32'd0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("flush_full_in_reject_after", 32'(in_reject), 32'd0);
    check("flush_full_occupancy_after", 32'(occupancy), 32'd0);

    // Asynchronous reset with two entries queued
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1'b1, 16'(16'h0030 + i));
    end
    next_cycle();
    drive(1'b0, 16'h0);
    #1;
    check("pre_reset_occupancy", 32'(occupancy), 32'd2);
    reset = 1'b0;
    #1;
    check("async_reset_out_en", 32'(out_en), 32'd0);
    check("async_reset_occupancy", 32'(occupancy), 32'd0);
    check("async_reset_in_reject", 32'(in_reject), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    repeat (3) next_cycle();
    drive(1'b1, 16'h0040);
    next_cycle();
    drive(1'b1, 16'h0041);
    #1;
    check("post_reset_first_pc", 32'(out_pc), 32'h0040);
    check("post_reset_occupancy", 32'(occupancy), 32'd1);
    next_cycle();
    drive(1'b0, 16'h0);
    out_reject = 1'b0;
    #1;
    check("post_reset_head_pc", 32'(out_pc), 32'h0040);
    next_cycle();
    #1;
    check("post_reset_second_pc", 32'(out_pc), 32'h0041);
    next_cycle();
    #1;
    check("post_reset_drained", 32'(occupancy), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Zero-latency pass-through, consumed then stalled
    next_cycle();
    drive(1'b1, 16'h0060);
    in_instr   = 32'h1C0005FD;
    out_reject = 1'b0;
    #1;
    check("bypass_out_en", 32'(out_en), 32'd1);
    check("bypass_out_instr", out_instr, 32'h1C0005FD);
    check("bypass_occupancy", 32'(occupancy), 32'd0);
    next_cycle();
    drive(1'b0, 16'h0);
    #1;
    check("bypass_consumed_occupancy", 32'(occupancy), 32'd0);
    next_cycle();
    drive(1'b1, 16'h0061);
    in_instr   = 32'h1C0005FD;
    out_reject = 1'b1;
    #1;
    check("bypass_stall_out_en", 32'(out_en), 32'd1);
    check("bypass_stall_out_instr", out_instr, 32'h1C0005FD);
    next_cycle();
    drive(1'b0, 16'h0);
    #1;
    check("bypass_stall_occupancy", 32'(occupancy), 32'd1);
    check("bypass_stall_head_pc", 32'(out_pc), 32'h0061);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
